fifo_rd_word_packer: RTL and testbench

- Read-side consumer of the 8-bit async FIFO, running entirely in the read clock domain.
- Pops bytes with rinc while rempty is low and packs BYTES_PER_WORD bytes little-endian into one word.
- Presents the word downstream on a valid/ready handshake.
- Directly drives the FIFO's rinc and consumes its rdata/rempty.

---
 rtl/fifo_rd_word_packer.sv | 140 ++++++++++++++
 tb/tb_fifo_rd_word_packer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_word_packer.sv
// fifo_rd_word_packer: read-domain consumer of an 8-bit async FIFO.
// It pops bytes while the FIFO is non-empty and packs BYTES_PER_WORD of
// them little-endian into one word. The word is then offered downstream
// on a valid/ready handshake.
// Optional feature macro: WORD_TIMEOUT_EN flushes a partial word after
// TIMEOUT_CYCLES idle cycles. When the macro is undefined, a partial word
// waits indefinitely for more bytes.
module fifo_rd_word_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                 rclk,
  input  logic                                 rrst_n,
  input  logic [DATA_WIDTH-1:0]                rdata,
  input  logic                                 rempty,
  output logic                                 rinc,
  output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] out_data,
  output logic [BYTES_PER_WORD-1:0]            out_keep,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int CW = $clog2(BYTES_PER_WORD + 1);
  localparam int WW = DATA_WIDTH * BYTES_PER_WORD;
  localparam logic [CW-1:0] FULL = CW'(BYTES_PER_WORD);
  localparam logic [CW-1:0] LAST = CW'(BYTES_PER_WORD - 1);

  // Reject illegal configurations at elaboration.
  if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("fifo_rd_word_packer: parameter out of legal range");
  end

  typedef enum logic {FILL = 1'b0, OUT = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             byte_cnt_q, byte_cnt_d;
  logic                      rd_pend_q;
  logic [WW-1:0]             buf_q, buf_d;
  logic [BYTES_PER_WORD-1:0] keep_q, keep_d;
  logic                      room;
  logic                      handshake;
  logic                      timeout;

  // A pop is allowed only if the byte it returns still has a free slot,
  // counting the byte already in flight from the previous pop.
  assign room      = ({1'b0, byte_cnt_q} + {{CW{1'b0}}, rd_pend_q}) < {1'b0, FULL};
  assign rinc      = rrst_n && (state_q == FILL) && !rempty && room;
  assign handshake = (state_q == OUT) && out_ready;

  assign out_valid = (state_q == OUT);
  assign out_data  = buf_q;
  assign out_keep  = out_valid ? keep_q : '0;

`ifdef WORD_TIMEOUT_EN
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       idle;

  assign idle    = (state_q == FILL) && (byte_cnt_q != '0) && (byte_cnt_q < FULL) &&
                   !rd_pend_q && rempty;
  assign timeout = idle && (idle_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // Idle counter: counts starved cycles of a partial word and saturates at 255.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (rd_pend_q || handshake) begin
      idle_cnt_d = '0;
    end else if (idle && (idle_cnt_q != 8'hFF)) begin
      idle_cnt_d = idle_cnt_q + 8'd1;
    end
  end

  // Idle counter register.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next state: capture in-flight bytes, seal the word, release on handshake.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    keep_d     = keep_q;
    case (state_q)
      FILL: begin
        if (rd_pend_q) begin
          // The in-flight byte is always committed by the FIFO, even if
          // rempty has just risen.
          for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (byte_cnt_q == CW'(i)) buf_d[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
          end
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST) begin
            state_d = OUT;
            keep_d  = '1;
          end
        end else if (timeout) begin
          state_d = OUT;
          for (int i = 0; i < BYTES_PER_WORD; i++) begin
            keep_d[i] = (CW'(i) < byte_cnt_q);
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d    = FILL;
          byte_cnt_d = '0;
          buf_d      = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, counters and word buffer; reset discards any partial word.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q    <= FILL;
      byte_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      buf_q      <= '0;
      keep_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      rd_pend_q  <= rinc;
      buf_q      <= buf_d;
      keep_q     <= keep_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_word_packer.sv
// Testbench for fifo_rd_word_packer: a behavioural FIFO read side feeds the
// packer, and a negedge monitor records handshaked words and protocol faults.
module tb_fifo_rd_word_packer;

  localparam int DW  = 8;
  localparam int BPW = 4;
  localparam int TO  = 16;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          rempty;
  logic          rinc;
  logic [31:0]   out_data;
  logic [3:0]    out_keep;
  logic          out_valid;
  logic          out_ready = 1'b0;

  always #5 rclk = ~rclk;

  fifo_rd_word_packer #(
    .DATA_WIDTH(DW), .BYTES_PER_WORD(BPW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // FIFO model: rdata updates the cycle after rinc is sampled.
  logic [7:0] mem [0:4095];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  logic gate_empty = 1'b0;

  always_comb rempty = (wr_ptr == rd_ptr) || gate_empty;

  always @(posedge rclk) begin
    if (rinc) begin
      rdata  <= mem[rd_ptr[11:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor
  int viol_empty = 0;
  int viol_hold  = 0;
  int pop_cnt    = 0;
  int vcnt       = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  logic [3:0]  prev_keep  = '0;
  logic [31:0] got_w [$];
  logic [3:0]  got_k [$];

  always @(negedge rclk) begin
    if (rinc && rempty) viol_empty <= viol_empty + 1;
    if (rrst_n && prev_stall &&
        (out_valid !== 1'b1 || out_data !== prev_data || out_keep !== prev_keep))
      viol_hold <= viol_hold + 1;
    prev_stall <= rrst_n && out_valid && !out_ready;
    prev_data  <= out_data;
    prev_keep  <= out_keep;
    if (rinc) pop_cnt <= pop_cnt + 1;
    if (out_valid) vcnt <= vcnt + 1;
    if (rrst_n && out_valid && out_ready) begin
      got_w.push_back(out_data);
      got_k.push_back(out_keep);
    end
  end

  int checks   = 0;
  int failures = 0;
  int gi       = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[11:0]] = b;
    wr_ptr++;
  endtask

  // Wait (bounded) for the next handshaked word and compare it.
  task automatic expect_word(input string nm, input logic [31:0] ew, input logic [3:0] ek,
                             input bit tog);
    int n;
    n = 0;
    while (got_w.size() <= gi && n < 200) begin
      if (tog) gate_empty = ~gate_empty;
      tick();
      n++;
    end
    gate_empty = 1'b0;
    if (got_w.size() <= gi) begin
      chk({nm, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({nm, "_data"}, got_w[gi], ew);
      chk({nm, "_keep"}, got_k[gi], ek);
      gi++;
    end
  endtask

  typedef struct {
    logic [7:0]  b [4];
    bit          tog;
    logic [31:0] exp_w;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int p0, v0, e0, h0, n, nbytes, berr;
    logic [31:0] w;
    logic [7:0]  eb;

    tbl[0].b = '{8'h11, 8'h22, 8'h33, 8'h44}; tbl[0].tog = 1'b0; tbl[0].exp_w = 32'h44332211;
    tbl[1].b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3}; tbl[1].tog = 1'b1; tbl[1].exp_w = 32'hA3A2A1A0;
    tbl[2].b = '{8'hFF, 8'h00, 8'h80, 8'h7F}; tbl[2].tog = 1'b0; tbl[2].exp_w = 32'h7F8000FF;
    tbl[3].b = '{8'h01, 8'h02, 8'h03, 8'h04}; tbl[3].tog = 1'b1; tbl[3].exp_w = 32'h04030201;

    // Reset state
    rrst_n = 1'b0;
    tick(); tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_keep", out_keep, 4'h0);
    chk("rst_rinc", rinc, 1'b0);
    rrst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Table vectors: single words, optionally with rempty toggling per cycle
    for (int i = 0; i < 4; i++) begin
      p0 = pop_cnt; v0 = vcnt; e0 = viol_empty;
      for (int k = 0; k < 4; k++) push(tbl[i].b[k]);
      expect_word($sformatf("vec%0d", i), tbl[i].exp_w, 4'hF, tbl[i].tog);
      repeat (6) tick();
      chk($sformatf("vec%0d_pops", i), pop_cnt - p0, 4);
      chk($sformatf("vec%0d_vcycles", i), vcnt - v0, 1);
      chk($sformatf("vec%0d_rinc_empty", i), viol_empty - e0, 0);
    end

    // Backpressure: 8 bytes queued, downstream stalls 10 cycles
    out_ready = 1'b0;
    h0 = viol_hold;
    for (int k = 1; k <= 8; k++) push(8'(k));
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("bp_valid", out_valid, 1'b1);
    p0 = pop_cnt;
    repeat (10) tick();
    chk("bp_pops_stalled", pop_cnt - p0, 0);
    chk("bp_data_held", out_data, 32'h04030201);
    chk("bp_keep_held", out_keep, 4'hF);
    out_ready = 1'b1;
    expect_word("bp_w0", 32'h04030201, 4'hF, 1'b0);
    expect_word("bp_w1", 32'h08070605, 4'hF, 1'b0);
    chk("bp_hold_viol", viol_hold - h0, 0);
    repeat (4) tick();

    // Reset in the middle of a word
    push(8'h91); push(8'h92);
    repeat (6) tick();
    rrst_n = 1'b0;
    tick();
    chk("midrst_rinc", rinc, 1'b0);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", out_data, 32'h0);
    chk("midrst_keep", out_keep, 4'h0);
    rrst_n = 1'b1;
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    expect_word("midrst_word", 32'h54535251, 4'hF, 1'b0);
    repeat (4) tick();

    // Partial word left starving
`ifdef WORD_TIMEOUT_EN
    out_ready = 1'b0;
    push(8'hBB); push(8'hCC);
    repeat (18) tick();
    chk("to_valid_early", out_valid, 1'b0);
    tick();
    chk("to_valid", out_valid, 1'b1);
    chk("to_data", out_data, 32'h0000CCBB);
    chk("to_keep", out_keep, 4'b0011);
    out_ready = 1'b1;
    expect_word("to_word", 32'h0000CCBB, 4'b0011, 1'b0);
`else
    push(8'hBB); push(8'hCC);
    v0 = vcnt;
    repeat (100) tick();
    chk("noto_valid_cycles", vcnt - v0, 0);
    push(8'hDD); push(8'hEE);
    expect_word("noto_word", 32'hEEDDCCBB, 4'hF, 1'b0);
`endif
    repeat (4) tick();

    // Random rempty / out_ready over 1000 bytes
    p0 = pop_cnt; e0 = viol_empty; h0 = viol_hold;
    for (int j = 0; j < 1000; j++) push(8'((j * 37 + 5) & 255));
    begin
      int start_gi;
      start_gi = gi;
      nbytes = 0; berr = 0; n = 0;
      while (nbytes < 1000 && n < 30000) begin
        gate_empty = ($urandom_range(0, 3) == 0);
        out_ready  = ($urandom_range(0, 1) == 1);
        tick();
        n++;
        while (gi < got_w.size()) begin
          w = got_w[gi];
          for (int k = 0; k < 4; k++) begin
            if (got_k[gi][k]) begin
              eb = 8'((nbytes * 37 + 5) & 255);
              if (w[k*8 +: 8] !== eb) berr++;
              nbytes++;
            end
          end
          gi++;
        end
      end
      gate_empty = 1'b0;
      out_ready  = 1'b1;
      chk("rand_words_seen", (gi > start_gi), 1'b1);
    end
    repeat (20) tick();
    chk("rand_bytes", nbytes, 1000);
    chk("rand_byte_errors", berr, 0);
    chk("rand_pops", pop_cnt - p0, 1000);
    chk("rand_rinc_empty", viol_empty - e0, 0);
    chk("rand_hold_viol", viol_hold - h0, 0);
    chk("rand_extra_words", got_w.size() - gi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
